rfphoenix_vec_permute: RTL

- Multi-cycle, parametrised vector permute unit sitting beside the per-lane vector ALU in the execute stage.
- Takes cross-lane operations (compress, expand, shuffle, slide, broadcast-extract) out of the combinational ALU path.
- Processes CHUNK elements per cycle at 16/32/64-bit element precision, with a valid/ready request/response handshake.
- Adds behaviour the combinational ALU lacks: expand, zero-fill on out-of-range indices, an element count result, and back-pressure.

---
 rtl/rfphoenix_vec_permute_pkg.sv | 36 +++
 rtl/rfphoenix_vec_permute_chunk.sv | 98 +++++++++
 rtl/rfphoenix_vec_permute.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rfphoenix_vec_permute_pkg.sv
// Shared types for the vector permute unit: op/precision encodings and element-count helpers.
package rfphoenix_vec_permute_pkg;

    typedef enum logic [2:0] {
        PERM_CMPRSS = 3'd0,
        PERM_EXPND  = 3'd1,
        PERM_SHUF   = 3'd2,
        PERM_SLUP   = 3'd3,
        PERM_SLDN   = 3'd4,
        PERM_EXTB   = 3'd5
    } permute_op_t;

    typedef enum logic [1:0] {
        PRC16  = 2'd0,
        PRC32  = 2'd1,
        PRC64  = 2'd2,
        PRC128 = 2'd3
    } prec_t;

    function automatic int unsigned elem_bits(input prec_t prc);
        case (prc)
            PRC16:   return 16;
            PRC32:   return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int unsigned nelem(input prec_t prc, input int unsigned vw);
        return vw / elem_bits(prc);
    endfunction

    function automatic logic is_reserved(input logic [2:0] op, input prec_t prc);
        return (op > PERM_EXTB) || (prc == PRC128);
    endfunction

endpackage

// File: rtl/rfphoenix_vec_permute_chunk.sv
// Combinational permute step over CHUNK consecutive elements starting at base.
module rfphoenix_perm_chunk
    import rfphoenix_vec_permute_pkg::*;
#(
    parameter int unsigned VW    = 512,
    parameter int unsigned CHUNK = 4
) (
    input  logic [VW-1:0]    a,
    input  logic [VW-1:0]    b,
    input  logic [VW-1:0]    acc,
    input  logic [7:0]       base,
    input  logic [7:0]       ptr,
    input  logic [VW/16-1:0] mask,
    input  permute_op_t      op,
    input  prec_t            prc,
    input  logic [7:0]       imm,
    output logic [VW-1:0]    acc_next,
    output logic [7:0]       ptr_inc
);

    function automatic logic [63:0] get_el(input logic [VW-1:0] v, input int unsigned idx,
                                           input int unsigned es);
        logic [VW-1:0] s;
        s = v >> (idx * es);
        if (es == 16)      return {48'd0, s[15:0]};
        else if (es == 32) return {32'd0, s[31:0]};
        else               return s[63:0];
    endfunction

    function automatic logic [VW-1:0] set_el(input logic [VW-1:0] v, input int unsigned idx,
                                             input int unsigned es, input logic [63:0] val);
        logic [63:0]   em;
        logic [VW-1:0] m;
        logic [VW-1:0] d;
        em = (es >= 64) ? '1 : ((64'd1 << es) - 64'd1);
        m  = VW'(em) << (idx * es);
        d  = VW'(val & em) << (idx * es);
        return (v & ~m) | d;
    endfunction

    always_comb begin
        int unsigned   es;
        int unsigned   ne;
        int unsigned   cnt;
        int unsigned   idx;
        logic [63:0]   val;
        logic [63:0]   bi;
        logic [VW/16-1:0] ms;
        acc_next = acc;
        cnt      = 0;
        es       = elem_bits(prc);
        ne       = nelem(prc, VW);
        for (int j = 0; j < CHUNK; j++) begin
            idx = 32'(base) + 32'(j);
            val = '0;
            ms  = mask >> idx;
            bi  = get_el(b, idx, es);
            if (idx < ne) begin
                // cnt is the running prefix count of mask bits seen so far in this chunk
                unique case (op)
                    PERM_CMPRSS: begin
                        if (ms[0]) begin
                            acc_next = set_el(acc_next, 32'(ptr) + cnt, es, get_el(a, idx, es));
                            cnt++;
                        end
                    end
                    PERM_EXPND: begin
                        if (ms[0]) begin
                            acc_next = set_el(acc_next, idx, es, get_el(a, 32'(ptr) + cnt, es));
                            cnt++;
                        end else begin
                            acc_next = set_el(acc_next, idx, es, bi);
                        end
                    end
                    PERM_SHUF: begin
                        if (bi < 64'(ne)) val = get_el(a, 32'(bi), es);
                        acc_next = set_el(acc_next, idx, es, val);
                    end
                    PERM_SLUP: begin
                        if (idx >= 32'(imm)) val = get_el(a, idx - 32'(imm), es);
                        acc_next = set_el(acc_next, idx, es, val);
                    end
                    PERM_SLDN: begin
                        if (idx + 32'(imm) < ne) val = get_el(a, idx + 32'(imm), es);
                        acc_next = set_el(acc_next, idx, es, val);
                    end
                    PERM_EXTB: begin
                        if (32'(imm) < ne) val = get_el(a, 32'(imm), es);
                        acc_next = set_el(acc_next, idx, es, val);
                    end
                    default: ;
                endcase
            end
        end
        ptr_inc = 8'(cnt);
    end

endmodule

// File: rtl/rfphoenix_vec_permute.sv
// Multi-cycle cross-lane permute unit with valid/ready request and response handshakes.
module rfphoenix_vec_permute
    import rfphoenix_vec_permute_pkg::*;
#(
    parameter int unsigned NLANES = 16,
    parameter int unsigned CHUNK  = 4,
    parameter int unsigned TAGW   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [1:0]             req_prc,
    input  logic [NLANES*32-1:0]   req_a,
    input  logic [NLANES*32-1:0]   req_b,
    input  logic [NLANES*2-1:0]    req_mask,
    input  logic [7:0]             req_imm,
    input  logic [TAGW-1:0]        req_tag,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NLANES*32-1:0]   rsp_o,
    output logic [7:0]             rsp_cnt,
    output logic [TAGW-1:0]        rsp_tag,
    output logic                   rsp_err
);

    localparam int unsigned VW = NLANES * 32;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q;
    logic [VW-1:0]    a_q, b_q, acc_next;
    logic [VW/16-1:0] mask_q;
    logic [2:0]       op_q;
    prec_t            prc_q;
    logic [7:0]       imm_q, idx_q, ptr_q, ptr_inc, ne_run;
    logic             last, counting;

    assign ne_run   = 8'(nelem(prc_q, VW));
    assign last     = ({1'b0, idx_q} + 9'(CHUNK)) >= {1'b0, ne_run};
    assign counting = (op_q == PERM_CMPRSS) || (op_q == PERM_EXPND);

    rfphoenix_perm_chunk #(
        .VW    (VW),
        .CHUNK (CHUNK)
    ) u_chunk (
        .a        (a_q),
        .b        (b_q),
        .acc      (rsp_o),
        .base     (idx_q),
        .ptr      (ptr_q),
        .mask     (mask_q),
        .op       (permute_op_t'(op_q)),
        .prc      (prc_q),
        .imm      (imm_q),
        .acc_next (acc_next),
        .ptr_inc  (ptr_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_o     <= '0;
            rsp_cnt   <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mask_q    <= '0;
            op_q      <= '0;
            prc_q     <= PRC16;
            imm_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        a_q       <= req_a;
                        b_q       <= req_b;
                        mask_q    <= req_mask;
                        op_q      <= req_op;
                        prc_q     <= prec_t'(req_prc);
                        imm_q     <= req_imm;
                        rsp_tag   <= req_tag;
                        rsp_o     <= '0;
                        rsp_cnt   <= '0;
                        idx_q     <= '0;
                        ptr_q     <= '0;
                        req_ready <= 1'b0;
                        if (is_reserved(req_op, prec_t'(req_prc))) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            rsp_err <= 1'b0;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    rsp_o <= acc_next;
                    ptr_q <= ptr_q + ptr_inc;
                    idx_q <= idx_q + 8'(CHUNK);
                    if (last) begin
                        state_q   <= StDone;
                        rsp_valid <= 1'b1;
                        rsp_cnt   <= counting ? (ptr_q + ptr_inc) : ne_run;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
